// File: rtl/ysyx_041514_if_fetch_pkg.sv
// Shared definitions for the IF fetch responder: FSM encodings, control-bus
// bit positions and the PC reset address.
package ysyx_041514_if_fetch_pkg;

  typedef enum logic [1:0] {
    YSYX_041514_IF_IDLE = 2'd0,
    YSYX_041514_IF_ADDR = 2'd1,
    YSYX_041514_IF_DATA = 2'd2,
    YSYX_041514_IF_HOLD = 2'd3
  } if_state_e;

  localparam int CTRLBUS_W  = 6;
  localparam int CTRLBUS_IF = 1;

  localparam logic [31:0] PC_RESET_ADDR = 32'h8000_0000;

endpackage

// File: rtl/ysyx_041514_if_linebuf.sv
// One-entry line buffer: last fetched bus beat, its tag and a valid bit.
// Invalidation wins over a refill in the same cycle, and an invalidate also
// masks a hit in that cycle so a fence.i always forces a miss.
module ysyx_041514_if_linebuf #(
  parameter int TAG_W  = 29,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              refill_i,
  input  logic [TAG_W-1:0]  refill_tag_i,
  input  logic [DATA_W-1:0] refill_data_i,
  input  logic              inval_i
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;

  // Entry storage: invalidate has priority over refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end else if (refill_i) begin
      valid_q <= 1'b1;
      tag_q   <= refill_tag_i;
      data_q  <= refill_data_i;
    end
  end

  // Lookup compare.
  always_comb begin
    hit_o   = valid_q & (tag_q == lookup_tag_i) & ~inval_i;
    rdata_o = data_q;
  end

endmodule

// File: rtl/ysyx_041514_if_fetch.sv
// IF-side instruction fetch responder. Accepts fetch addresses from the PC
// register, performs at most one bus read at a time, and presents the
// selected 32-bit instruction with its PC to IF/ID. Responses belonging to
// flushed fetches are discarded via the drop flag.
// Optional feature: define YSYX_041514_IF_LINEBUF_EN to add a one-entry
// line buffer that serves repeat hits to the same 8-byte beat without a bus
// access.
module ysyx_041514_if_fetch
  import ysyx_041514_if_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BUS_W  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_req_i,
  input  logic [ADDR_W-1:0]    pc_next_i,
  input  logic [CTRLBUS_W-1:0] stall_valid_i,
  input  logic [CTRLBUS_W-1:0] flush_valid_i,
  input  logic                 fencei_i,
  output logic                 mem_req_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [BUS_W-1:0]     mem_rdata_i,
  output logic                 inst_valid_o,
  output logic [31:0]          inst_o,
  output logic [ADDR_W-1:0]    inst_pc_o,
  output logic                 inst_misalign_o,
  output logic                 if_busy_o
);

  if_state_e         state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic [31:0]       inst_q;
  logic              misalign_q;

  logic        stall_if, flush_if;
  logic        accept_ok, accept, misalign_req;
  logic        beat_done, beat_drop;
  logic [31:0] rdata_word;
  logic        lb_hit;
  logic [31:0] lb_word;

  assign stall_if     = stall_valid_i[CTRLBUS_IF];
  assign flush_if     = flush_valid_i[CTRLBUS_IF];
  assign misalign_req = (pc_next_i[1:0] != 2'b00);

  // A new request is considered only when idle or when a held instruction is
  // being consumed; a flush in the same cycle always rejects it.
  assign accept_ok = (state_q == YSYX_041514_IF_IDLE) |
                     ((state_q == YSYX_041514_IF_HOLD) & ~stall_if);
  assign accept    = accept_ok & read_req_i & ~stall_if & ~flush_if;

  assign beat_done  = (state_q == YSYX_041514_IF_DATA) & mem_rvalid_i;
  assign beat_drop  = beat_done & (drop_q | flush_if);
  assign rdata_word = req_pc_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];

`ifdef YSYX_041514_IF_LINEBUF_EN
  logic          lb_hit_raw;
  logic [63:0]   lb_data;

  ysyx_041514_if_linebuf #(
    .TAG_W  (ADDR_W - 3),
    .DATA_W (64)
  ) u_linebuf (
    .clk           (clk),
    .rst           (rst),
    .lookup_tag_i  (pc_next_i[ADDR_W-1:3]),
    .hit_o         (lb_hit_raw),
    .rdata_o       (lb_data),
    .refill_i      (beat_done & ~beat_drop),
    .refill_tag_i  (req_pc_q[ADDR_W-1:3]),
    .refill_data_i (mem_rdata_i[63:0]),
    .inval_i       (fencei_i | beat_drop)
  );

  assign lb_hit  = lb_hit_raw & ~misalign_req;
  assign lb_word = pc_next_i[2] ? lb_data[63:32] : lb_data[31:0];
`else
  assign lb_hit  = 1'b0;
  assign lb_word = 32'h0;
`endif

  logic unused_bits;
  assign unused_bits = ^{fencei_i, stall_valid_i, flush_valid_i, mem_rdata_i, lb_word};

  // State and drop-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= YSYX_041514_IF_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and drop-flag logic.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      YSYX_041514_IF_IDLE: begin
        if (accept)
          state_d = (misalign_req | lb_hit) ? YSYX_041514_IF_HOLD : YSYX_041514_IF_ADDR;
      end
      YSYX_041514_IF_ADDR: begin
        if (flush_if) drop_d = 1'b1;
        if (mem_gnt_i) state_d = YSYX_041514_IF_DATA;
      end
      YSYX_041514_IF_DATA: begin
        if (flush_if) drop_d = 1'b1;
        if (mem_rvalid_i) begin
          drop_d  = 1'b0;
          state_d = beat_drop ? YSYX_041514_IF_IDLE : YSYX_041514_IF_HOLD;
        end
      end
      YSYX_041514_IF_HOLD: begin
        if (flush_if)
          state_d = YSYX_041514_IF_IDLE;
        else if (!stall_if) begin
          if (accept)
            state_d = (misalign_req | lb_hit) ? YSYX_041514_IF_HOLD : YSYX_041514_IF_ADDR;
          else
            state_d = YSYX_041514_IF_IDLE;
        end
      end
      default: state_d = YSYX_041514_IF_IDLE;
    endcase
  end

  // Outputs decoded from state; no combinational path from the bus inputs.
  always_comb begin
    mem_req_o       = (state_q == YSYX_041514_IF_ADDR);
    if_busy_o       = (state_q == YSYX_041514_IF_ADDR) | (state_q == YSYX_041514_IF_DATA);
    inst_valid_o    = (state_q == YSYX_041514_IF_HOLD);
    inst_misalign_o = misalign_q & (state_q == YSYX_041514_IF_HOLD);
    mem_addr_o      = {req_pc_q[ADDR_W-1:3], 3'b000};
    inst_o          = inst_q;
    inst_pc_o       = req_pc_q;
  end

  // Request PC and instruction capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc_q   <= '0;
      inst_q     <= '0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      req_pc_q   <= pc_next_i;
      misalign_q <= misalign_req;
      if (misalign_req)
        inst_q <= 32'h0;
      else if (lb_hit)
        inst_q <= lb_word;
    end else if (beat_done & ~beat_drop) begin
      inst_q <= rdata_word;
    end
  end

endmodule

// File: tb/tb_ysyx_041514_if_fetch.sv
// Directed bench for the IF fetch responder: miss timing, bus backpressure,
// flush handling, stall hold, misaligned fetch, reset abort and (when the
// macro is defined) line buffer hits.
module tb_ysyx_041514_if_fetch;
  import ysyx_041514_if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_req_i;
  logic [31:0] pc_next_i;
  logic [5:0]  stall_valid_i;
  logic [5:0]  flush_valid_i;
  logic        fencei_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_misalign_o;
  logic        if_busy_o;

  int n_chk = 0;
  int n_bad = 0;

  ysyx_041514_if_fetch #(.ADDR_W(32), .BUS_W(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .read_req_i      (read_req_i),
    .pc_next_i       (pc_next_i),
    .stall_valid_i   (stall_valid_i),
    .flush_valid_i   (flush_valid_i),
    .fencei_i        (fencei_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_misalign_o (inst_misalign_o),
    .if_busy_o       (if_busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full miss with immediate grant and rvalid one cycle later; ends in HOLD.
  task automatic do_miss(input string tag, input logic [31:0] pc,
                         input logic [63:0] beat, input logic [31:0] exp_inst);
    read_req_i = 1'b1;
    pc_next_i  = pc;
    step();
    read_req_i = 1'b0;
    chk({tag, ".req"},  mem_req_o, 1);
    chk({tag, ".addr"}, mem_addr_o, {pc[31:3], 3'b000});
    chk({tag, ".v1"},   inst_valid_o, 0);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk({tag, ".busy"}, if_busy_o, 1);
    chk({tag, ".v2"},   inst_valid_o, 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = beat;
    step();
    mem_rvalid_i = 1'b0;
    chk({tag, ".valid"}, inst_valid_o, 1);
    chk({tag, ".inst"},  inst_o, exp_inst);
    chk({tag, ".pc"},    inst_pc_o, pc);
    chk({tag, ".mis"},   inst_misalign_o, 0);
    chk({tag, ".nbusy"}, if_busy_o, 0);
  endtask

  initial begin
    rst = 1'b0;
    read_req_i = 1'b0; pc_next_i = 32'h0;
    stall_valid_i = '0; flush_valid_i = '0; fencei_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", inst_valid_o, 0);
    chk("rst.req",   mem_req_o, 0);
    chk("rst.busy",  if_busy_o, 0);
    chk("rst.inst",  inst_o, 0);
    chk("rst.pc",    inst_pc_o, 0);
    chk("rst.mis",   inst_misalign_o, 0);
    rst = 1'b1;
    step();

    // Basic miss, upper word selected.
    do_miss("miss", 32'h8000_0004, 64'h11111111_22222222, 32'h11111111);
    step();
    chk("miss.idle", inst_valid_o, 0);

    // Grant withheld for 4 cycles.
    read_req_i = 1'b1; pc_next_i = 32'h8000_0010;
    step();
    read_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp.req",  mem_req_o, 1);
      chk("bp.addr", mem_addr_o, 32'h8000_0010);
      chk("bp.busy", if_busy_o, 1);
      step();
    end
    chk("bp.req5", mem_req_o, 1);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk("bp.data", mem_req_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h99998888_AAAA5555;
    step();
    mem_rvalid_i = 1'b0;
    chk("bp.valid", inst_valid_o, 1);
    chk("bp.inst",  inst_o, 32'hAAAA5555);
    step();

    // Flush while in DATA: beat is dropped.
    read_req_i = 1'b1; pc_next_i = 32'h8000_0020;
    step();
    read_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    flush_valid_i[CTRLBUS_IF] = 1'b1;
    step();
    flush_valid_i = '0;
    chk("fd.busy", if_busy_o, 1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEADDEAD_DEADDEAD;
    step();
    mem_rvalid_i = 1'b0;
    chk("fd.valid", inst_valid_o, 0);
    chk("fd.busy2", if_busy_o, 0);
    step();
    chk("fd.valid2", inst_valid_o, 0);
    do_miss("after_fd", 32'h8000_0100, 64'hCAFEF00D_12345678, 32'h12345678);
    step();

    // Stall in HOLD keeps outputs frozen and blocks a new request.
    do_miss("pre_stall", 32'h8000_0104, 64'hCAFEF00D_12345678, 32'hCAFEF00D);
    stall_valid_i[CTRLBUS_IF] = 1'b1;
    read_req_i = 1'b1; pc_next_i = 32'h8000_0200;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st.valid", inst_valid_o, 1);
      chk("st.inst",  inst_o, 32'hCAFEF00D);
      chk("st.pc",    inst_pc_o, 32'h8000_0104);
      chk("st.req",   mem_req_o, 0);
    end
    stall_valid_i = '0;
    read_req_i = 1'b0;
    step();
    chk("st.rel_valid", inst_valid_o, 0);
    chk("st.rel_req",   mem_req_o, 0);

    // Misaligned fetch.
    read_req_i = 1'b1; pc_next_i = 32'h8000_0002;
    step();
    read_req_i = 1'b0;
    chk("mis.valid", inst_valid_o, 1);
    chk("mis.flag",  inst_misalign_o, 1);
    chk("mis.inst",  inst_o, 0);
    chk("mis.pc",    inst_pc_o, 32'h8000_0002);
    chk("mis.req",   mem_req_o, 0);
    step();
    chk("mis.end_valid", inst_valid_o, 0);
    chk("mis.end_flag",  inst_misalign_o, 0);
    chk("mis.end_req",   mem_req_o, 0);

    // Flush and request together: request rejected.
    read_req_i = 1'b1; pc_next_i = 32'h8000_0300;
    flush_valid_i[CTRLBUS_IF] = 1'b1;
    step();
    read_req_i = 1'b0; flush_valid_i = '0;
    chk("fr.req",  mem_req_o, 0);
    chk("fr.busy", if_busy_o, 0);

    // Flush in ADDR: address phase completes, beat is dropped.
    read_req_i = 1'b1; pc_next_i = 32'h8000_0400;
    step();
    read_req_i = 1'b0;
    flush_valid_i[CTRLBUS_IF] = 1'b1;
    step();
    flush_valid_i = '0;
    chk("fa.req",  mem_req_o, 1);
    chk("fa.addr", mem_addr_o, 32'h8000_0400);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0BADBEEF_0BADBEEF;
    step();
    mem_rvalid_i = 1'b0;
    chk("fa.valid", inst_valid_o, 0);
    chk("fa.busy",  if_busy_o, 0);

    // Back-to-back: HOLD accepts the next request directly.
    do_miss("b2b0", 32'h8000_0500, 64'h55555555_66666666, 32'h66666666);
    do_miss("b2b1", 32'h8000_0508, 64'h77777777_88888888, 32'h88888888);
    step();

    // Same beat fetched again.
`ifdef YSYX_041514_IF_LINEBUF_EN
    do_miss("lb0", 32'h8000_0000, 64'h44444444_33333333, 32'h33333333);
    read_req_i = 1'b1; pc_next_i = 32'h8000_0004;
    step();
    read_req_i = 1'b0;
    chk("lb.hit_valid", inst_valid_o, 1);
    chk("lb.hit_inst",  inst_o, 32'h44444444);
    chk("lb.hit_pc",    inst_pc_o, 32'h8000_0004);
    chk("lb.hit_req",   mem_req_o, 0);
    step();
    fencei_i = 1'b1;
    step();
    fencei_i = 1'b0;
    do_miss("lb.fence", 32'h8000_0004, 64'h44444444_33333333, 32'h44444444);
    step();
`else
    do_miss("nolb0", 32'h8000_0000, 64'h44444444_33333333, 32'h33333333);
    do_miss("nolb1", 32'h8000_0004, 64'h44444444_33333333, 32'h44444444);
    step();
`endif

    // Reset mid-transaction aborts; a late rvalid is ignored.
    read_req_i = 1'b1; pc_next_i = 32'h8000_0600;
    step();
    read_req_i = 1'b0;
    chk("rm.req", mem_req_o, 1);
    rst = 1'b0;
    #1;
    chk("rm.req_rst",  mem_req_o, 0);
    chk("rm.busy_rst", if_busy_o, 0);
    step();
    rst = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h12121212_34343434;
    step();
    mem_rvalid_i = 1'b0;
    chk("rm.valid", inst_valid_o, 0);
    chk("rm.busy",  if_busy_o, 0);
    chk("rm.pc",    inst_pc_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_041514_if_fetch.md
# ysyx_041514_if_fetch

Instruction-fetch responder on the IF side of the pre-IF/IF split. Each cycle the PC register issues a fetch address (`pc_next`, `read_req`). This block accepts that address, services it over the instruction memory bus, and returns the 32-bit instruction together with its PC to the IF/ID boundary. While a fetch is outstanding it raises a stall request to the pipeline controller, and it discards responses that belong to flushed fetches.

## Interface
- `ADDR_W`, default 32: fetch address width (`ysyx_041514_NPC_ADDR_BUS`).
- `BUS_W`, default 64: memory read data width; the instruction is selected from the beat by address bit 2.
- `clk`  input  1  single clock, all logic on its rising edge.
- `rst`  input  1  asynchronous active-low reset (asserted low, released synchronously by the top level).
- `read_req_i`  input  1  fetch request from the PC register.
- `pc_next_i`  input  ADDR_W  fetch address.
- `stall_valid_i`  input  6  pipeline stall vector; this block uses bit `ysyx_041514_CTRLBUS_IF`.
- `flush_valid_i`  input  6  pipeline flush vector; this block uses bit `ysyx_041514_CTRLBUS_IF`.
- `fencei_i`  input  1  fence.i pulse.
- `mem_req_o`  output  1  bus address-phase valid.
- `mem_addr_o`  output  ADDR_W  bus address, aligned to 8 bytes.
- `mem_gnt_i`  input  1  address accepted.
- `mem_rvalid_i`  input  1  read data valid.
- `mem_rdata_i`  input  BUS_W  read data.
- `inst_valid_o`  output  1  instruction valid to IF/ID.
- `inst_o`  output  32  instruction.
- `inst_pc_o`  output  ADDR_W  PC of `inst_o`.
- `inst_misalign_o`  output  1  `pc[1:0] != 0`; asserted together with `inst_valid_o`.
- `if_busy_o`  output  1  stall request to the controller.

## Operation
- FSM states: IDLE, ADDR, DATA, HOLD.
- **Accept condition:** `read_req_i & ~stall[IF]`. It is only evaluated in IDLE, or in HOLD once the stall has been released. On accept, `pc_next_i` is latched into `req_pc`.
- **Misaligned address** (`pc[1:0] != 0`): no bus access is made. Go to HOLD with `inst_o = 0`, `inst_misalign_o = 1`.
- **Normal miss:** IDLE -> ADDR. `mem_req_o = 1` with `mem_addr_o = {req_pc[ADDR_W-1:3], 3'b0}`, held stable until `mem_gnt_i`; then go to DATA. On `mem_rvalid_i`, capture `rdata[32*req_pc[2] +: 32]` and go to HOLD.
- **HOLD:** `inst_valid_o = 1` with the captured instruction and `req_pc`.
  - If `stall[IF]` is high, the outputs stay frozen.
  - Otherwise, accept the next request in the same cycle (HOLD -> ADDR), or return to IDLE if there is no request.
- **Flush** (`flush[IF]`):
  - IDLE and HOLD go to IDLE; `inst_valid_o` drops the next cycle.
  - ADDR stays in ADDR until the grant (the bus transaction cannot be withdrawn), and a `drop` flag is set.
  - DATA sets `drop`. When the data arrives with `drop` set, it is discarded, `drop` is cleared, and the FSM goes to IDLE.
- **Flush and read_req in the same cycle:** the flush wins; that request is not accepted. The PC register reissues it after the flush.
- `if_busy_o = (state == ADDR) | (state == DATA)`. It is combinational from state only; there is no path from `mem_*` inputs.
- **Reset values:** state IDLE, `drop = 0`, `req_pc = 0`, `inst_o = 0`, `inst_valid_o = 0`, `inst_misalign_o = 0`, `mem_req_o = 0`, `if_busy_o = 0`.
- **Reset mid-transaction:** the FSM aborts to IDLE. Any late `mem_rvalid_i` after reset is ignored while in IDLE.

## Timing
- **Miss latency:** accept at cycle N; `mem_req_o` at N+1; with the grant at N+1 and rvalid at N+2, `inst_valid_o` is asserted at N+3.
- **Linebuffer hit:** accept at N, `inst_valid_o` at N+1, with no bus activity.
- `mem_addr_o` must not change while `mem_req_o = 1` and `mem_gnt_i = 0`.
- At most one outstanding bus transaction.

## Configuration
- Macro: `YSYX_041514_IF_LINEBUF_EN`.
- **Defined:** a one-entry buffer holds the last 64-bit beat, its tag `addr[ADDR_W-1:3]`, and a valid bit.
  - An accepted aligned request whose tag matches goes directly to HOLD from the buffer.
  - Every completed, non-dropped beat refills the buffer.
  - `fencei_i`, reset, and a dropped beat clear the valid bit. `fencei_i` in the same cycle as a hit forces a miss.
- **Undefined:** every aligned fetch goes to the bus; the buffer logic and the tag compare are absent.

## Structure
- Shared package/header (`sysconfig.v`) holds:
  - the FSM state encodings `ysyx_041514_IF_IDLE/ADDR/DATA/HOLD` (2 bits);
  - `CTRLBUS_IF`;
  - `PC_RESET_ADDR`.
- Natural sub-module: `ysyx_041514_if_linebuf`, containing the tag, valid bit and data, with lookup and refill ports. It is instantiated only under the macro.

## Test plan
- **Miss:** `pc_next = 0x8000_0004`, grant immediately, rdata `0x11111111_22222222` -> `mem_addr_o = 0x8000_0000`, then `inst_o = 0x11111111`, `inst_pc_o = 0x8000_0004`, `inst_valid_o` at N+3.
- **Backpressure:** hold `mem_gnt_i = 0` for 4 cycles -> `mem_addr_o` is stable and `if_busy_o = 1` throughout.
- **Flush in DATA:** flush at N+2, rvalid at N+3 -> no `inst_valid_o`, FSM returns to IDLE, and the next request at `0x8000_0100` returns correct data.
- **Stall in HOLD:** assert `stall[IF]` for 3 cycles -> `inst_o` and `inst_pc_o` stay frozen and a concurrent `read_req_i` is not accepted.
- **Misaligned:** `pc_next = 0x8000_0002` -> `inst_misalign_o = 1` with `inst_valid_o` at N+1 and `mem_req_o` never asserted.
- **Linebuffer (macro on):** `0x8000_0000` followed by `0x8000_0004` -> the second fetch is valid at N+1 with no `mem_req_o`. After `fencei_i`, the same address misses.
